// File: rtl/weight_loader.sv
// Byte-stream weight loader: packs BATCH_SIZE bytes per word and writes them to
// the weight RAM at consecutive batch addresses, tracking checksum and count.
module weight_loader #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned BATCH_SIZE   = 8,
  parameter int unsigned WEIGHT_COUNT = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             wr_en,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [DATA_WIDTH*BATCH_SIZE-1:0] wr_data,
  output logic [BATCH_SIZE-1:0]            wr_mask,
  output logic                             busy,
  output logic                             done,
  output logic [DATA_WIDTH-1:0]            checksum,
  output logic [ADDR_WIDTH:0]              byte_count
);

  localparam int unsigned LANE_W = $clog2(BATCH_SIZE);
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned WORD_W = DATA_WIDTH * BATCH_SIZE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                                     r_state;
  logic [LANE_W-1:0]                          r_lane;
  logic [ADDR_WIDTH-1:0]                      r_ptr;
  logic [BATCH_SIZE-1:0][DATA_WIDTH-1:0]      r_buf;
  logic [DATA_WIDTH-1:0]                      r_sum;
  logic [CNT_W-1:0]                           r_cnt;
  logic                                       r_in_ready;
  logic                                       r_wr_en;
  logic [ADDR_WIDTH-1:0]                      r_wr_addr;
  logic [WORD_W-1:0]                          r_wr_data;
  logic [BATCH_SIZE-1:0]                      r_wr_mask;
  logic                                       r_busy;
  logic                                       r_done;

  logic [BATCH_SIZE-1:0][DATA_WIDTH-1:0]      w_word;
  logic [BATCH_SIZE-1:0]                      w_mask;
  logic                                       w_accept;
  logic                                       w_last;
  logic                                       w_lane_full;
  logic                                       w_flush;

  // Pack buffer with the incoming byte merged in, and the filled-lane mask.
  always_comb begin
    w_word         = r_buf;
    w_word[r_lane] = in_data;
    w_mask         = '0;
    for (int i = 0; i < int'(BATCH_SIZE); i++) begin
      w_mask[i] = (LANE_W'(i) <= r_lane);
    end
  end

  // in_ready is only ever set while in LOAD, so it alone qualifies accepts.
  assign w_accept    = in_valid & r_in_ready;
  assign w_last      = (r_cnt == CNT_W'(WEIGHT_COUNT - 1));
  assign w_lane_full = (r_lane == LANE_W'(BATCH_SIZE - 1));
  assign w_flush     = w_accept & (w_last | w_lane_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lane     <= '0;
      r_ptr      <= '0;
      r_buf      <= '0;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_mask  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ptr      <= base_addr;
            r_sum      <= '0;
            r_cnt      <= '0;
            r_lane     <= '0;
            r_buf      <= '0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_sum <= r_sum + in_data;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_flush) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_ptr;
              r_wr_data <= w_word;
              r_wr_mask <= w_mask;
              r_ptr     <= r_ptr + ADDR_WIDTH'(BATCH_SIZE);
              r_lane    <= '0;
              r_buf     <= '0;
            end else begin
              r_buf  <= w_word;
              r_lane <= r_lane + LANE_W'(1);
            end
            // Final byte: done lands with the last write strobe.
            if (w_last) begin
              r_done     <= 1'b1;
              r_in_ready <= 1'b0;
              r_state    <= FINISH;
            end
          end
        end
        FINISH: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign wr_mask    = r_wr_mask;
  assign busy       = r_busy;
  assign done       = r_done;
  assign checksum   = r_sum;
  assign byte_count = r_cnt;

endmodule
